peripheral_interconnect: RTL
============================

// Module: peripheral_interconnect
// PURPOSE
//  Parametrised successor to the single-device peripheral hookup. Sits between the core's
//  peripheral request port and NUM_SLAVES memory-mapped devices (LEDs, UART, GPIO, timer...).
//  Decodes address windows, forwards one transaction at a time, returns read data/response.
//  Flags unmapped accesses and, optionally, hung slaves, with an error response.
// PARAMETERS
//  NUM_SLAVES     4             number of slave channels (1..16)
//  DATA_WIDTH     32            data bus width
//  ADDR_WIDTH     32            address bus width
//  BASE_ADDRESS   32'h0000_1000 start of slave 0 window
//  SPAN_BITS      8             window size per slave = 2**SPAN_BITS bytes, contiguous
//  TIMEOUT_CYCLES 255           slave wait limit (used only with PERIPH_TIMEOUT_EN)
//  ERROR_DATA     32'hDEAD_BEEF read data returned on error
// PORTS
//  clk                       in   1            clock, all logic on rising edge
//  rst                       in   1            synchronous reset, active-high
//  peripheral_read_request   in   1            core read strobe, held until response
//  peripheral_write_request  in   1            core write strobe, held until response
//  peripheral_addr           in   ADDR_WIDTH   core byte address
//  peripheral_write_data     in   DATA_WIDTH   core write data
//  peripheral_read_data      out  DATA_WIDTH   registered read data
//  peripheral_response       out  1            one-cycle completion pulse
//  bus_error                 out  1            sticky: unmapped/timeout seen; cleared by rst only
//  slave_read                out  NUM_SLAVES   one-hot read strobe
//  slave_write               out  NUM_SLAVES   one-hot write strobe
//  slave_addr                out  ADDR_WIDTH   latched address (full, not offset)
//  slave_write_data          out  DATA_WIDTH   latched write data
//  slave_read_data           in   NUM_SLAVES*DATA_WIDTH  flat; slave i at [i*DATA_WIDTH +: DATA_WIDTH]
//  slave_response            in   NUM_SLAVES   slave done, sampled only for selected slave
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, timeout counter 0. Reset mid-transaction aborts;
//   strobes low on the next edge; no response is emitted.
//  FSM IDLE->ACCESS->RESP->IDLE (ERROR replaces ACCESS on a decode miss).
//  IDLE: on read|write, latch addr/wdata/op. Write wins if both are high (read dropped).
//   Hit: idx = (addr-BASE)>>SPAN_BITS < NUM_SLAVES and addr >= BASE -> ACCESS.
//   Miss -> ERROR.
//  ACCESS: slave_read/write[idx] held high from the cycle after the request is latched.
//   When slave_response[idx]=1, capture slave_read_data[idx] (writes: capture 0), drop strobes,
//   go to RESP. Responses from non-selected slaves are ignored.
//  ERROR: read_data<=ERROR_DATA, bus_error<=1 -> RESP (total latency 2 cycles).
//  RESP: peripheral_response=1 for exactly one cycle. read_data is held until the next
//   capture. Returns to IDLE, which ignores requests for that one cycle so a held strobe
//   is not re-issued. Core must deassert its strobe the cycle after response.
//  Min hit latency: request cycle N -> strobe N+1 -> slave resp N+1 -> response N+2.
//  Address arithmetic is unsigned ADDR_WIDTH. Wrap-around below BASE counts as a miss.
//  The top window edge (BASE + NUM_SLAVES<<SPAN_BITS) is exclusive.
// CONFIGURATION
//  PERIPH_TIMEOUT_EN defined: ACCESS counts cycles. At TIMEOUT_CYCLES without slave_response,
//   drop the strobe, read_data<=ERROR_DATA, bus_error<=1 -> RESP. Counter is cleared on
//   entering ACCESS.
//  Not defined: no counter; ACCESS waits indefinitely; TIMEOUT_CYCLES unused.
// STRUCTURE
//  Package peripheral_bus_pkg: typedef enum logic [1:0] {IDLE,ACCESS,ERROR,RESP} pbus_state_t;
//   localparam DEFAULT_ERROR_DATA; the clog2-based index width function.
//  Sub-module periph_addr_decoder (combinational): addr -> hit, idx, one-hot select.
//   Reused later by the DMA master.
//  Top holds the FSM, latches, read-data mux/register and timeout counter.
// TESTING
//  Write 0xA5 to 0x1000, slave0 responds in 1 cycle -> slave_write=0001, data 0xA5,
//   response pulse at N+2.
//  Read 0x1304, slave3 returns 0x1234_5678 after 5 cycles -> read_data=0x12345678,
//   single response pulse, strobes then 0.
//  Read 0x2000 (miss) -> no slave strobe, read_data=0xDEADBEEF, bus_error=1, response at N+2.
//  Read and write both high at 0x1100 -> only slave_write[1] asserted.
//   Also: spurious slave_response[2] during the slave1 access is ignored.
//  PERIPH_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave2 silent -> strobe drops after 8 cycles,
//   ERROR_DATA, bus_error=1. Without the macro, still waiting at cycle 100.
//  rst high mid-ACCESS -> strobes 0 next edge, no response, bus_error 0, next access works.

Source files
------------

// File: rtl/peripheral_bus_pkg.sv
// Shared types and helpers for the peripheral bus interconnect and its address decoder.
package peripheral_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERROR  = 2'd2,
    RESP   = 2'd3
  } pbus_state_t;

  localparam logic [31:0] DEFAULT_ERROR_DATA = 32'hDEAD_BEEF;

  // Width of a slave index; a single slave still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/periph_addr_decoder.sv
// Combinational address decoder: maps a byte address onto one of NUM_SLAVES
// contiguous windows of 2**SPAN_BITS bytes starting at BASE_ADDRESS.
// Addresses below the base (unsigned wrap) or at/after the top edge are misses.
module periph_addr_decoder
  import peripheral_bus_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    NUM_SLAVES   = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = 32'h0000_1000,
  parameter int                    SPAN_BITS    = 8,
  parameter int                    IDX_W        = idx_width(NUM_SLAVES)
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  hit_o,
  output logic [IDX_W-1:0]      idx_o,
  output logic [NUM_SLAVES-1:0] sel_o
);

  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] window;

  // Window index from the offset; hit only if at/above base and below the top edge.
  always_comb begin
    offset = addr_i - BASE_ADDRESS;
    window = offset >> SPAN_BITS;
    hit_o  = (addr_i >= BASE_ADDRESS) && (window < ADDR_WIDTH'(NUM_SLAVES));
    idx_o  = window[IDX_W-1:0];
    sel_o  = '0;
    if (hit_o) sel_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/peripheral_interconnect.sv
// Peripheral interconnect: decodes core requests onto NUM_SLAVES windows, runs one
// transaction at a time and returns registered read data with a one-cycle response.
// Optional feature macro: PERIPH_TIMEOUT_EN (abort a hung slave after TIMEOUT_CYCLES).
//
//   state  | meaning
//   IDLE   | waiting for a request (ignores requests for one cycle after RESP)
//   ACCESS | strobe held on selected slave until it responds (or times out)
//   ERROR  | decode miss: load ERROR_DATA, set bus_error
//   RESP   | one-cycle completion pulse to the core
module peripheral_interconnect
  import peripheral_bus_pkg::*;
#(
  parameter int                    NUM_SLAVES     = 4,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS   = 32'h0000_1000,
  parameter int                    SPAN_BITS      = 8,
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] ERROR_DATA     = DEFAULT_ERROR_DATA
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             peripheral_read_request,
  input  logic                             peripheral_write_request,
  input  logic [ADDR_WIDTH-1:0]            peripheral_addr,
  input  logic [DATA_WIDTH-1:0]            peripheral_write_data,
  output logic [DATA_WIDTH-1:0]            peripheral_read_data,
  output logic                             peripheral_response,
  output logic                             bus_error,
  output logic [NUM_SLAVES-1:0]            slave_read,
  output logic [NUM_SLAVES-1:0]            slave_write,
  output logic [ADDR_WIDTH-1:0]            slave_addr,
  output logic [DATA_WIDTH-1:0]            slave_write_data,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slave_read_data,
  input  logic [NUM_SLAVES-1:0]            slave_response
);

  localparam int IDX_W = idx_width(NUM_SLAVES);

  pbus_state_t           state_q, state_d;
  logic                  dec_hit;
  logic [IDX_W-1:0]      dec_idx;
  logic [NUM_SLAVES-1:0] dec_sel;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  write_q;
  logic [IDX_W-1:0]      idx_q;
  logic [NUM_SLAVES-1:0] sel_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  bus_err_q;
  logic                  hold_off_q;

  logic accept;
  logic sel_resp;
  logic timeout_hit;

  periph_addr_decoder #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .NUM_SLAVES  (NUM_SLAVES),
    .BASE_ADDRESS(BASE_ADDRESS),
    .SPAN_BITS   (SPAN_BITS),
    .IDX_W       (IDX_W)
  ) u_decoder (
    .addr_i(peripheral_addr),
    .hit_o (dec_hit),
    .idx_o (dec_idx),
    .sel_o (dec_sel)
  );

  assign accept   = (state_q == IDLE) && !hold_off_q &&
                    (peripheral_read_request || peripheral_write_request);
  assign sel_resp = slave_response[idx_q];

`ifdef PERIPH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] cnt_q;

  assign timeout_hit = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Cycles spent in ACCESS; restarts whenever a new transaction is accepted.
  always_ff @(posedge clk) begin
    if (rst)                     cnt_q <= '0;
    else if (accept)             cnt_q <= '0;
    else if (state_q == ACCESS)  cnt_q <= cnt_q + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a slave response in the same cycle as the timeout wins.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = dec_hit ? ACCESS : ERROR;
      ACCESS:  if (sel_resp || timeout_hit) state_d = RESP;
      ERROR:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latches, read-data capture and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      idx_q      <= '0;
      sel_q      <= '0;
      rdata_q    <= '0;
      bus_err_q  <= 1'b0;
      hold_off_q <= 1'b0;
    end else begin
      hold_off_q <= (state_q == RESP);
      if (accept) begin
        addr_q  <= peripheral_addr;
        wdata_q <= peripheral_write_data;
        write_q <= peripheral_write_request;
        idx_q   <= dec_idx;
        sel_q   <= dec_sel;
      end
      if (state_q == ACCESS && sel_resp) begin
        rdata_q <= write_q ? '0 : slave_read_data[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
      end else if ((state_q == ACCESS && timeout_hit) || state_q == ERROR) begin
        rdata_q   <= ERROR_DATA;
        bus_err_q <= 1'b1;
      end
    end
  end

  // Outputs decoded from state and latched request.
  always_comb begin
    slave_read           = '0;
    slave_write          = '0;
    if (state_q == ACCESS) begin
      if (write_q) slave_write = sel_q;
      else         slave_read  = sel_q;
    end
    peripheral_response  = (state_q == RESP);
    peripheral_read_data = rdata_q;
    bus_error            = bus_err_q;
    slave_addr           = addr_q;
    slave_write_data     = wdata_q;
  end

endmodule
